// File: rtl/modmul_arbiter_pkg.sv
// modmul_arbiter_pkg: operand width and FSM state shared by the ModMul arbiter and its bench
package modmul_arbiter_pkg;
  localparam int P_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, CLEAR, BUSY, RESP} state_t;
endpackage

// File: rtl/modmul_arbiter_rr_pick.sv
// rr_pick: round-robin priority pick, first set request after last grant with wrap
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any_valid
);
  localparam int W = $clog2(N);
  // Walk from the farthest offset down so the nearest requester after last wins.
  always_comb begin
    grant = '0;
    any_valid = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        grant = W'((int'(last) + i) % N);
        any_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/modmul_arbiter.sv
// modmul_arbiter: shares one external ModMul between NUM_REQ requesters with round-robin grant and timeout
module modmul_arbiter
  import modmul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][P_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][P_WIDTH-1:0]   req_b,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [P_WIDTH-1:0]                rsp_r,
  output logic                              rsp_err,
  output logic [P_WIDTH-1:0]                mm_a,
  output logic [P_WIDTH-1:0]                mm_b,
  output logic                              mm_enable,
  output logic                              mm_clear,
  input  logic [P_WIDTH-1:0]                mm_r,
  input  logic                              mm_done
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [IW-1:0] last_grant, grant;
  logic any_valid;
  logic [CW-1:0] cnt;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req_valid),
    .last(last_grant),
    .grant(grant),
    .any_valid(any_valid)
  );
  assign req_ready = (state == IDLE && any_valid) ? NUM_REQ'(1) << grant : '0;
  assign rsp_valid = state == RESP;
  assign mm_enable = state == BUSY;
  assign mm_clear = state == CLEAR;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      rsp_id <= '0;
      rsp_r <= '0;
      rsp_err <= 1'b0;
      mm_a <= '0;
      mm_b <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          mm_a <= req_a[grant];
          mm_b <= req_b[grant];
          rsp_id <= grant;
          last_grant <= grant;
          state <= CLEAR;
        end
        CLEAR: begin
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          // A done arriving on the timeout cycle still delivers the real result.
          if (mm_done) begin
            rsp_r <= mm_r;
            rsp_err <= 1'b0;
            state <= RESP;
          end else if (cnt == CW'(TIMEOUT)) begin
            rsp_r <= '0;
            rsp_err <= 1'b1;
            state <= RESP;
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/modmul_arbiter.md
MODMUL_ARBITER -- requirements
Module: modmul_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one ModMul instance (2..8).
REQ-002 Parameter: TIMEOUT, default 1023, maximum BUSY cycles before abort.
REQ-003 Port: clk  in  1  single clock, all logic rising-edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  in  NUM_REQ  per-requester operation request.
REQ-006 Port: req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 Port: req_a, req_b  in  NUM_REQ x P_WIDTH  per-requester operands.
REQ-008 Port: rsp_valid  out  1  result available.
REQ-009 Port: rsp_ready  in  1  consumer accepts result.
REQ-010 Port: rsp_id  out  clog2(NUM_REQ)  index of the requester owning the result.
REQ-011 Port: rsp_r  out  P_WIDTH  modular product.
REQ-012 Port: rsp_err  out  1  result aborted by timeout; rsp_r is 0 when set.
REQ-013 Port: mm_a, mm_b  out  P_WIDTH  operands to the shared ModMul.
REQ-014 Port: mm_enable  out  1  ModMul enable, held high for the whole operation.
REQ-015 Port: mm_clear  out  1  one-cycle clear, ORed with reset into the ModMul reset by the integrator.
REQ-016 Port: mm_r  in  P_WIDTH  ModMul remainder.
REQ-017 Port: mm_done  in  1  ModMul level done.

Function
REQ-018 FSM states: IDLE, CLEAR, BUSY, RESP.
REQ-019 IDLE: if any req_valid, grant g = first set bit searching round-robin from last_grant+1 (wrapping); req_ready[g]=1 combinationally that cycle; latch req_a[g], req_b[g], g; last_grant<=g; next CLEAR.
REQ-020 IDLE with no req_valid: all req_ready 0, stay IDLE.
REQ-021 req_ready is 0 in every state except IDLE; requests arriving during an operation wait, and their operands are not sampled.
REQ-022 CLEAR: mm_clear=1, mm_enable=0 for exactly one cycle; next BUSY; busy counter cleared.
REQ-023 BUSY: mm_enable=1, mm_a/mm_b = latched operands (stable through operation); counter increments each cycle.
REQ-024 BUSY with mm_done=1: rsp_r<=mm_r, rsp_err<=0; next RESP, same edge.
REQ-025 BUSY with counter==TIMEOUT and mm_done=0: rsp_r<=0, rsp_err<=1; next RESP.
REQ-026 mm_done and timeout in the same cycle: mm_done wins (result, no error).
REQ-027 RESP: rsp_valid=1, rsp_id/rsp_r/rsp_err stable, mm_enable=0; on rsp_ready next IDLE; otherwise hold indefinitely.
REQ-028 mm_done is ignored outside BUSY.
REQ-029 Minimum request-to-result latency: 2 cycles + ModMul latency; back-to-back throughput: one operation per (3 + ModMul latency) cycles.
REQ-030 Fairness: a continuously asserted request is granted within NUM_REQ grants.

Reset
REQ-031 Reset (async assert, any state, including mid-BUSY) forces IDLE; last_grant = NUM_REQ-1 so requester 0 has first priority.
REQ-032 Reset values: req_ready 0, rsp_valid 0, rsp_id 0, rsp_r 0, rsp_err 0, mm_a 0, mm_b 0, mm_enable 0, mm_clear 0, counter 0.
REQ-033 An operation interrupted by reset is discarded; no response is produced.

Structure
REQ-034 P_WIDTH and the FSM state enum belong in the shared ModMul package; NUM_REQ and TIMEOUT remain local parameters.
REQ-035 The round-robin priority pick is a separate sub-module, rr_pick (inputs: request vector and last grant; output: grant index and any-valid).
REQ-036 The ModMul instance is outside the block; the block only drives and observes it.

Verification
REQ-037 Bench uses a ModMul model with done after 5 cycles, computing (a*b) mod 97 at P_WIDTH=8.
REQ-038 Single request: req_valid[2], a=10, b=20 -> req_ready[2] one cycle; rsp_valid after 7 cycles with rsp_id=2, rsp_r=6, rsp_err=0.
REQ-039 All four requests held high continuously -> grant order 0,1,2,3,0; each req_ready pulses exactly once per grant.
REQ-040 rsp_ready held low 10 cycles in RESP -> rsp outputs stable, no req_ready pulses, mm_enable=0; after release, next grant within 1 cycle.
REQ-041 Model never asserts done, TIMEOUT=15 -> RESP after 16 BUSY cycles with rsp_err=1, rsp_r=0.
REQ-042 Reset asserted in BUSY cycle 3 -> all outputs at reset values immediately; rsp_valid is never asserted; next grant goes to requester 0.
